// File: rtl/buzzer_round_if.sv
// Pin-level bundle between the quiz host/buzzer front end and the round controller.
interface buzzer_round_if;
   logic [2:0] buzz;
   logic       btn_award;
   logic       btn_penalty;
   logic       btn_clear;
   logic [3:0] ones;
   logic [3:0] tens;
   logic [2:0] thousands;
   logic [2:0] winner_led;
   logic       beep;

   modport master (
      output buzz, btn_award, btn_penalty, btn_clear,
      input  ones, tens, thousands, winner_led, beep
   );

   modport slave (
      input  buzz, btn_award, btn_penalty, btn_clear,
      output ones, tens, thousands, winner_led, beep
   );
endinterface

// File: rtl/buzzer_round_ctrl.sv
// Quiz round controller: first-buzz lockout, host award/penalty, BCD scores, display and beep.
// Optional macro REBUZZ_LOCKOUT_EN keeps penalized teams out of later rounds until clear.
module buzzer_round_ctrl #(
   parameter int ANSWER_CYCLES = 500_000_000,
   parameter int SHOW_CYCLES   = 100_000_000,
   parameter int BEEP_CYCLES   = 20_000_000,
   parameter int AWARD_PTS     = 1,
   parameter int PENALTY_PTS   = 1
) (
   input  logic          clk_100MHz,
   input  logic          reset,
   buzzer_round_if.slave bus
);

   localparam logic [31:0] L_ANS_LAST  = 32'(ANSWER_CYCLES - 1);
   localparam logic [31:0] L_SHOW_LAST = 32'(SHOW_CYCLES - 1);
   localparam logic [31:0] L_BEEP_LAST = 32'(BEEP_CYCLES - 1);

   typedef enum logic [1:0] {S_ARMED, S_LOCKED, S_RESULT} state_t;

   state_t          r_state, w_state_nxt;
   logic [2:0]      r_buzz_s1, r_buzz_s2, r_buzz_d;
   logic [2:0]      r_btn_s1, r_btn_s2, r_btn_d;   // {clear, penalty, award}
   logic [2:0]      w_buzz_ev, w_btn_ev, w_buzz_ok;
   logic [31:0]     r_cnt, r_beep_cnt;
   logic [1:0]      r_disp, w_disp_nxt, r_win, w_win_idx;
   logic [2:0][7:0] r_score, w_score_nxt;
   logic [7:0]      w_disp_score;
   logic [3:0]      r_ones, r_tens;
   logic [2:0]      r_winner_led, w_thousands;
   logic            r_beep;
   logic            w_clr, w_timeout, w_lock, w_award, w_pen, w_rotate, w_res_done;

   function automatic logic [7:0] bcd_upd(input logic [7:0] s, input logic add);
      int v;
      v = int'(s[7:4]) * 10 + int'(s[3:0]);
      if (add) v = (v + AWARD_PTS > 99) ? 99 : v + AWARD_PTS;
      else     v = (v < PENALTY_PTS) ? 0 : v - PENALTY_PTS;
      return {4'(v / 10), 4'(v % 10)};
   endfunction

   // Two-flop synchronizers followed by a one-flop rising-edge detector
   always_ff @(posedge clk_100MHz) begin
      if (reset) begin
         r_buzz_s1 <= '0;
         r_buzz_s2 <= '0;
         r_buzz_d  <= '0;
         r_btn_s1  <= '0;
         r_btn_s2  <= '0;
         r_btn_d   <= '0;
      end else begin
         r_buzz_s1 <= bus.buzz;
         r_buzz_s2 <= r_buzz_s1;
         r_buzz_d  <= r_buzz_s2;
         r_btn_s1  <= {bus.btn_clear, bus.btn_penalty, bus.btn_award};
         r_btn_s2  <= r_btn_s1;
         r_btn_d   <= r_btn_s2;
      end
   end

   assign w_buzz_ev = r_buzz_s2 & ~r_buzz_d;
   assign w_btn_ev  = r_btn_s2 & ~r_btn_d;
   assign w_clr     = w_btn_ev[2];
   assign w_timeout = (r_cnt == L_ANS_LAST);

`ifdef REBUZZ_LOCKOUT_EN
   logic [2:0] r_mask;

   always_ff @(posedge clk_100MHz) begin
      if (reset || w_clr) r_mask <= '0;
      else if (w_pen)     r_mask <= r_mask | 3'(3'b001 << r_win);
   end

   assign w_buzz_ok = w_buzz_ev & ~r_mask;
`else
   assign w_buzz_ok = w_buzz_ev;
`endif

   always_comb begin
      w_win_idx = 2'd0;
      if (w_buzz_ok[0])      w_win_idx = 2'd0;
      else if (w_buzz_ok[1]) w_win_idx = 2'd1;
      else if (w_buzz_ok[2]) w_win_idx = 2'd2;
   end

   always_ff @(posedge clk_100MHz) begin
      if (reset) r_state <= S_ARMED;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      if (w_clr) w_state_nxt = S_ARMED;
      else begin
         case (r_state)
            S_ARMED:  if (|w_buzz_ok) w_state_nxt = S_LOCKED;
            S_LOCKED: if (w_btn_ev[0] || w_btn_ev[1] || w_timeout) w_state_nxt = S_RESULT;
            S_RESULT: if (r_cnt == L_SHOW_LAST) w_state_nxt = S_ARMED;
            default:  w_state_nxt = S_ARMED;
         endcase
      end
   end

   // Per-cycle action strobes; clear masks everything, award masks penalty/timeout
   always_comb begin
      w_lock     = !w_clr && (r_state == S_ARMED) && (|w_buzz_ok);
      w_award    = !w_clr && (r_state == S_LOCKED) && w_btn_ev[0];
      w_pen      = !w_clr && (r_state == S_LOCKED) && !w_btn_ev[0] && (w_btn_ev[1] || w_timeout);
      w_rotate   = !w_clr && (r_state == S_ARMED) && !(|w_buzz_ok) && (r_cnt == L_SHOW_LAST);
      w_res_done = !w_clr && (r_state == S_RESULT) && (r_cnt == L_SHOW_LAST);

      w_disp_nxt = r_disp;
      if (w_lock)        w_disp_nxt = w_win_idx;
      else if (w_rotate) w_disp_nxt = (r_disp == 2'd2) ? 2'd0 : r_disp + 2'd1;

      w_score_nxt = r_score;
      for (int i = 0; i < 3; i++) begin
         if ((w_award || w_pen) && (r_win == 2'(i)))
            w_score_nxt[i] = bcd_upd(r_score[i], w_award);
      end

      w_disp_score = w_score_nxt[0];
      for (int i = 1; i < 3; i++) begin
         if (w_disp_nxt == 2'(i)) w_disp_score = w_score_nxt[i];
      end

      case (r_disp)
         2'd1:    w_thousands = 3'b010;
         2'd2:    w_thousands = 3'b100;
         default: w_thousands = 3'b001;
      endcase
   end

   always_ff @(posedge clk_100MHz) begin
      if (reset) begin
         r_cnt        <= '0;
         r_beep_cnt   <= '0;
         r_beep       <= 1'b0;
         r_disp       <= 2'd0;
         r_win        <= 2'd0;
         r_score      <= '0;
         r_ones       <= '0;
         r_tens       <= '0;
         r_winner_led <= '0;
      end else begin
         if (w_clr || w_lock || w_award || w_pen || w_rotate || w_res_done) r_cnt <= '0;
         else                                                                r_cnt <= r_cnt + 32'd1;

         if (w_clr) begin
            r_beep     <= 1'b0;
            r_beep_cnt <= '0;
         end else if (w_lock) begin
            r_beep     <= 1'b1;
            r_beep_cnt <= '0;
         end else if (r_beep) begin
            if (r_beep_cnt == L_BEEP_LAST) begin
               r_beep     <= 1'b0;
               r_beep_cnt <= '0;
            end else begin
               r_beep_cnt <= r_beep_cnt + 32'd1;
            end
         end

         if (w_lock) r_win <= w_win_idx;

         if (w_clr || w_res_done) r_winner_led <= '0;
         else if (w_lock)         r_winner_led <= 3'(3'b001 << w_win_idx);

         r_disp  <= w_disp_nxt;
         r_score <= w_score_nxt;
         r_ones  <= w_disp_score[3:0];
         r_tens  <= w_disp_score[7:4];
      end
   end

   assign bus.ones       = r_ones;
   assign bus.tens       = r_tens;
   assign bus.thousands  = w_thousands;
   assign bus.winner_led = r_winner_led;
   assign bus.beep       = r_beep;

endmodule

// File: tb/tb_buzzer_round_ctrl.sv
// Directed scoreboard bench for buzzer_round_ctrl; instance B uses AWARD_PTS=5 for saturation.
module tb_buzzer_round_ctrl;

   logic clk;
   logic reset;
   int   n_tests = 0;
   int   n_fail  = 0;

   string       tag_q[$];
   logic [31:0] exp_q[$];

   buzzer_round_if u_a ();
   buzzer_round_if u_b ();

   buzzer_round_ctrl #(
      .ANSWER_CYCLES(50), .SHOW_CYCLES(20), .BEEP_CYCLES(8), .AWARD_PTS(1), .PENALTY_PTS(1)
   ) u_dut_a (
      .clk_100MHz(clk), .reset(reset), .bus(u_a.slave)
   );

   buzzer_round_ctrl #(
      .ANSWER_CYCLES(50), .SHOW_CYCLES(20), .BEEP_CYCLES(8), .AWARD_PTS(5), .PENALTY_PTS(1)
   ) u_dut_b (
      .clk_100MHz(clk), .reset(reset), .bus(u_b.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push(input string t, input logic [31:0] e);
      tag_q.push_back(t);
      exp_q.push_back(e);
   endtask

   task automatic pop(input logic [31:0] obs);
      string       t;
      logic [31:0] e;
      n_tests++;
      if (exp_q.size() == 0) begin
         n_fail++;
         $error("FAIL sb_empty: observed %0h, required a queued expectation", obs);
      end else begin
         t = tag_q.pop_front();
         e = exp_q.pop_front();
         assert (obs === e)
         else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", t, obs, e);
         end
      end
   endtask

   task automatic drive(input bit sel_b, input logic [2:0] bz, input logic aw,
                        input logic pe, input logic cl);
      if (sel_b) begin
         u_b.buzz = bz; u_b.btn_award = aw; u_b.btn_penalty = pe; u_b.btn_clear = cl;
      end else begin
         u_a.buzz = bz; u_a.btn_award = aw; u_a.btn_penalty = pe; u_a.btn_clear = cl;
      end
   endtask

   // One-cycle pin pulse; returns just after the edge where the event takes effect
   task automatic pulse(input bit sel_b, input logic [2:0] bz, input logic aw,
                        input logic pe, input logic cl);
      drive(sel_b, bz, aw, pe, cl);
      cyc(1);
      drive(sel_b, 3'b000, 1'b0, 1'b0, 1'b0);
      cyc(2);
   endtask

   function automatic logic [31:0] bcd(input int v);
      return {24'd0, 4'(v / 10), 4'(v % 10)};
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int sc;
      drive(1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 3'b000, 1'b0, 1'b0, 1'b0);
      reset = 1'b1;
      cyc(2);
      push("rst_score", bcd(0));   pop({24'd0, u_a.tens, u_a.ones});
      push("rst_thou", 3'b001);    pop(u_a.thousands);
      push("rst_led", 3'b000);     pop(u_a.winner_led);
      push("rst_beep", 1'b0);      pop(u_a.beep);
      reset = 1'b0;

      // idle rotation
      cyc(19); push("rot_0", 3'b001); pop(u_a.thousands);
      cyc(1);  push("rot_1", 3'b010); pop(u_a.thousands);
      cyc(20); push("rot_2", 3'b100); pop(u_a.thousands);
      cyc(20); push("rot_3", 3'b001); pop(u_a.thousands);
      cyc(10);
      push("idle_score", bcd(0)); pop({24'd0, u_a.tens, u_a.ones});
      push("idle_led", 3'b000);   pop(u_a.winner_led);
      push("idle_beep", 1'b0);    pop(u_a.beep);

      // simultaneous buzz 110: team1 wins, 3-cycle latency
      drive(1'b0, 3'b110, 1'b0, 1'b0, 1'b0);
      cyc(1);
      drive(1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
      push("lock_early", 3'b000); cyc(1); pop(u_a.winner_led);
      push("lock_led", 3'b010);   push("lock_thou", 3'b010); push("lock_beep", 1'b1);
      cyc(1);
      pop(u_a.winner_led); pop(u_a.thousands); pop(u_a.beep);
      push("beep_last", 1'b1); cyc(7); pop(u_a.beep);
      push("beep_off", 1'b0);  cyc(1); pop(u_a.beep);
      push("late_buzz_led", 3'b010); pulse(1'b0, 3'b100, 1'b0, 1'b0, 1'b0); pop(u_a.winner_led);

      // answer timeout for team1
      push("pre_timeout_led", 3'b010); cyc(38); pop(u_a.winner_led);
      push("timeout_score", bcd(0));   push("timeout_led", 3'b010);
      cyc(1);
      pop({24'd0, u_a.tens, u_a.ones}); pop(u_a.winner_led);
      push("result_hold", 3'b010); cyc(19); pop(u_a.winner_led);
      push("result_exit", 3'b000); push("result_thou", 3'b010);
      cyc(1);
      pop(u_a.winner_led); pop(u_a.thousands);

      // team0: award and penalty together, award wins
      push("t0_lock", 3'b001); pulse(1'b0, 3'b001, 1'b0, 1'b0, 1'b0); pop(u_a.winner_led);
      push("t0_award", bcd(1)); pulse(1'b0, 3'b000, 1'b1, 1'b1, 1'b0);
      pop({24'd0, u_a.tens, u_a.ones});
      push("t0_hold", 3'b001); cyc(19); pop(u_a.winner_led);
      push("t0_exit", 3'b000); cyc(1);  pop(u_a.winner_led);

      // clear beats award while locked
      push("t2_lock", 3'b100); pulse(1'b0, 3'b100, 1'b0, 1'b0, 1'b0); pop(u_a.winner_led);
      push("clr_led", 3'b000); push("clr_beep", 1'b0); push("clr_score", bcd(0));
      pulse(1'b0, 3'b000, 1'b1, 1'b0, 1'b1);
      pop(u_a.winner_led); pop(u_a.beep); pop({24'd0, u_a.tens, u_a.ones});
      push("post_clr_lock", 3'b010); pulse(1'b0, 3'b010, 1'b0, 1'b0, 1'b0); pop(u_a.winner_led);

      // reset mid-round clears team0's score of 1
      reset = 1'b1;
      cyc(1);
      push("mid_rst_score", bcd(0)); push("mid_rst_thou", 3'b001);
      push("mid_rst_led", 3'b000);   push("mid_rst_beep", 1'b0);
      pop({24'd0, u_a.tens, u_a.ones}); pop(u_a.thousands); pop(u_a.winner_led); pop(u_a.beep);
      reset = 1'b0;

      // penalty at zero floors, then team0 tries again
      push("pen_lock", 3'b001); pulse(1'b0, 3'b001, 1'b0, 1'b0, 1'b0); pop(u_a.winner_led);
      push("pen_floor", bcd(0)); pulse(1'b0, 3'b000, 1'b0, 1'b1, 1'b0);
      pop({24'd0, u_a.tens, u_a.ones});
      cyc(20);
`ifdef REBUZZ_LOCKOUT_EN
      push("rebuzz_t0", 3'b000); pulse(1'b0, 3'b001, 1'b0, 1'b0, 1'b0); pop(u_a.winner_led);
      push("rebuzz_t1", 3'b010); pulse(1'b0, 3'b010, 1'b0, 1'b0, 1'b0); pop(u_a.winner_led);
      pulse(1'b0, 3'b000, 1'b0, 1'b1, 1'b0);
      cyc(20);
      push("rebuzz_t2", 3'b100); pulse(1'b0, 3'b100, 1'b0, 1'b0, 1'b0); pop(u_a.winner_led);
      pulse(1'b0, 3'b000, 1'b0, 1'b1, 1'b0);
      cyc(20);
      push("all_locked", 3'b000); pulse(1'b0, 3'b111, 1'b0, 1'b0, 1'b0); pop(u_a.winner_led);
      pulse(1'b0, 3'b000, 1'b0, 1'b0, 1'b1);
      push("unlock_t0", 3'b001); pulse(1'b0, 3'b001, 1'b0, 1'b0, 1'b0); pop(u_a.winner_led);
`else
      push("rebuzz_t0", 3'b001); pulse(1'b0, 3'b001, 1'b0, 1'b0, 1'b0); pop(u_a.winner_led);
      push("rebuzz_clr", 3'b000); pulse(1'b0, 3'b000, 1'b0, 1'b0, 1'b1); pop(u_a.winner_led);
`endif

      // instance B: repeated awards of 5 to team2, saturate, penalty, award again
      sc = 0;
      for (int k = 0; k < 20; k++) begin
         pulse(1'b1, 3'b100, 1'b0, 1'b0, 1'b0);
         sc = (sc + 5 > 99) ? 99 : sc + 5;
         push($sformatf("b_award_%0d", k), bcd(sc));
         pulse(1'b1, 3'b000, 1'b1, 1'b0, 1'b0);
         pop({24'd0, u_b.tens, u_b.ones});
         cyc(20);
      end
      pulse(1'b1, 3'b100, 1'b0, 1'b0, 1'b0);
      push("b_pen_98", bcd(98)); pulse(1'b1, 3'b000, 1'b0, 1'b1, 1'b0);
      pop({24'd0, u_b.tens, u_b.ones});
      cyc(20);
      pulse(1'b1, 3'b100, 1'b0, 1'b0, 1'b0);
      push("b_98_plus5", bcd(99)); pulse(1'b1, 3'b000, 1'b1, 1'b0, 1'b0);
      pop({24'd0, u_b.tens, u_b.ones});
      push("b_thou", 3'b100); pop(u_b.thousands);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/buzzer_round_ctrl.md
Name: buzzer_round_ctrl

Overview:
- Round controller for the three-team quiz buzzer system.
- Detects the first buzzer press and locks out the other teams. Takes host award/penalty decisions, keeps a BCD score (0..99) per team, and enforces an answer timeout.
- Drives the 4-digit seven-segment display driver with ones/tens of the selected team's score and a one-hot team code on thousands.
- Also drives the team LEDs and a beep pulse.

Parameters:
- ANSWER_CYCLES, 500_000_000: answer window after lock, in clk cycles (5 s at 100 MHz).
- SHOW_CYCLES, 100_000_000: per-team display dwell in ARMED, and RESULT hold time.
- BEEP_CYCLES, 20_000_000: beep pulse length on lock.
- AWARD_PTS, 1: points added on award, legal range 1..9.
- PENALTY_PTS, 1: points subtracted on penalty/timeout, legal range 0..9.

Ports:
- clk_100MHz  in  1  system clock.
- reset  in  1  synchronous, active-high.
- buzz  in  3  team buzzers, debounced, asynchronous to clk, active-high; bit i = team i.
- btn_award  in  1  host "correct", debounced, active-high.
- btn_penalty  in  1  host "wrong", debounced, active-high.
- btn_clear  in  1  host "new round", debounced, active-high.
- ones  out  4  BCD ones digit of displayed team's score.
- tens  out  4  BCD tens digit of displayed team's score.
- thousands  out  3  displayed team code: team0=3'b001, team1=3'b010, team2=3'b100. Always exactly one-hot.
- winner_led  out  3  one-hot locked team; 0 when none.
- beep  out  1  buzzer sounder drive.

Behaviour:
- Reset is synchronous and active-high. All state is cleared on the first clk_100MHz edge with reset=1, including mid-round.
- Reset values: all scores 0, state=ARMED, display team=0, ones=0, tens=0, thousands=3'b001, winner_led=0, beep=0, all counters 0, lockout mask 0.
- Input conditioning:
  - buzz and the three buttons each pass through a 2-FF synchronizer, then a rising-edge detect.
  - Pin-to-event latency is 3 cycles. Levels held high generate no further events.
- States and transitions:
  - ARMED:
    - Display rotates team 0→1→2→0, advancing every SHOW_CYCLES.
    - A buzz edge from a non-locked-out team selects the winner. On simultaneous edges, the lowest index wins.
    - On a win: go to LOCKED, set winner_led to the winner, set display to the winner, start the answer counter, assert beep for BEEP_CYCLES.
    - Award, penalty and timeout are ignored in ARMED.
  - LOCKED:
    - All buzz edges are ignored.
    - btn_award adds AWARD_PTS to the winner's score, then go to RESULT.
    - btn_penalty subtracts PENALTY_PTS from the winner's score, then go to RESULT.
    - Answer counter reaching ANSWER_CYCLES-1 is treated exactly as a penalty.
    - Award and penalty in the same cycle: award wins, penalty is dropped.
  - RESULT:
    - Display holds the winner's updated score for SHOW_CYCLES, then return to ARMED.
    - winner_led is cleared on exit.
    - Rotation restarts from the winner's index with a fresh dwell.
- btn_clear: from any state, go to ARMED next cycle.
  - Clears winner_led, beep, counters and lockout mask.
  - Scores are kept.
  - Takes priority over every other event in the same cycle.
- Score arithmetic:
  - Stored as two BCD digits; every update produces valid BCD.
  - Award saturates at 99 (e.g. 95+9 → 99).
  - Penalty floors at 0 (e.g. 03−9 → 00).
  - Score updates are registered: ones/tens reflect the new value 1 cycle after the triggering event.
- beep:
  - Asserted for exactly BEEP_CYCLES cycles starting the cycle after lock.
  - Truncated by clear or reset.
  - Never re-triggered while LOCKED.
- Outputs are registered, except thousands, which is a direct decode of the display-team register. thousands is never 3'b000 and never multi-hot.

Optional Feature:
- Macro: REBUZZ_LOCKOUT_EN.
- Defined:
  - A penalty or timeout sets the winner's bit in a lockout mask.
  - Locked-out teams' buzz edges are ignored in ARMED until btn_clear or reset.
  - If all three teams are locked out, the controller stays ARMED with no possible winner until btn_clear.
- Undefined:
  - No mask exists; every team may buzz in each ARMED phase.

Test Plan (bench overrides ANSWER_CYCLES=50, SHOW_CYCLES=20, BEEP_CYCLES=8; AWARD_PTS=1 and PENALTY_PTS=1 except where stated):
- Reset, then idle 70 cycles → ones=0, tens=0; thousands steps 001→010→100→001 every 20 cycles; winner_led=0; beep=0.
- buzz=3'b110 in one cycle → lowest set index (team1) locks 3 cycles after the pin change: winner_led=3'b010, thousands=3'b010, beep high exactly 8 cycles. Later team2 press → no change.
- Team0 locked, btn_award and btn_penalty in the same cycle → team0 score 00→01; state RESULT for 20 cycles, then ARMED with winner_led=0.
- Team2 score 98, AWARD_PTS=5, award → 99. Team1 score 00, lock then no host input for 50 cycles → timeout penalty, score stays 00, RESULT entered.
- While LOCKED, assert btn_clear with btn_award in the same cycle → ARMED next cycle; score unchanged; beep=0. Then assert reset mid-round → all scores 0, thousands=3'b001.
- REBUZZ_LOCKOUT_EN defined:
  - Team0 penalized, then team0 buzz → ignored; team1 buzz → locks.
  - With all teams penalized, any buzz → ignored until btn_clear.
  - With the macro undefined, the first step instead shows team0 re-locking.
